prime_collector: RTL and testbench

- Downstream consumer of the prime-number scanner.
- Watches the scanner's outputs `numberChecked` and `prime`, and captures each distinct number flagged prime into a small FIFO.
- Presents captured primes on a valid/ready read port for a display or UART stage.
- Also keeps a running count of accepted primes and a sticky overflow flag.

---
 rtl/prime_pkg.sv | 6 +
 rtl/prime_sync_fifo.sv | 44 ++++
 rtl/prime_collector.sv | 75 +++++++
 tb/tb_prime_collector.sv | 134 +++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// prime_pkg: shared scanner/collector width, default FIFO depth and capture FSM encoding
package prime_pkg;
   localparam int DATA_W = 11;
   localparam int DEPTH  = 16;
   typedef enum logic {S_ARMED = 1'b0, S_HELD = 1'b1} cap_state_t;
endpackage

// File: rtl/prime_sync_fifo.sv
// prime_sync_fifo: synchronous FIFO with wrap-bit pointers and a registered first-word fall-through head
module prime_sync_fifo #(
   parameter int DATA_W = 11,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic [DATA_W-1:0] head
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W:0] wr_ptr, rd_ptr, wr_n, rd_n;
   logic pop_ok, push_ok;
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
   assign count = wr_ptr - rd_ptr;
   // a full FIFO still takes a push when the head leaves in the same cycle
   always_comb begin
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);
      wr_n    = wr_ptr + (ADDR_W+1)'(push_ok);
      rd_n    = rd_ptr + (ADDR_W+1)'(pop_ok);
   end
   // storage write, suppressed while in reset
   always_ff @(posedge clk)
      if (!rst && push_ok) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
   // pointers and head; the head bypasses the RAM when the new head is being written now
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_n;
         rd_ptr <= rd_n;
         if (wr_n != rd_n) head <= (rd_n == wr_ptr) ? push_data : mem[rd_n[ADDR_W-1:0]];
      end
   end
endmodule

// File: rtl/prime_collector.sv
// prime_collector: captures each distinct prime from the scanner into a FIFO; PRIME_COLLECTOR_GAP_EN adds max_gap
module prime_collector #(
   parameter int DATA_W = prime_pkg::DATA_W,
   parameter int DEPTH  = prime_pkg::DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] numberChecked,
   input  logic              prime,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   fifo_count,
   output logic [DATA_W-1:0] total_captured,
`ifdef PRIME_COLLECTOR_GAP_EN
   output logic [DATA_W-1:0] max_gap,
`endif
   output logic              overflow
);
   import prime_pkg::*;
   cap_state_t state, state_n;
   logic [DATA_W-1:0] last_num, last_num_n;
   logic cap, full, empty, pop, push_ok;
   assign rd_valid = !empty;
   assign pop      = rd_valid && rd_ready;
   assign push_ok  = cap && (!full || pop);
   // capture on the first prime after idle, or on a new value while primes keep coming
   always_comb begin
      state_n    = prime ? S_HELD : S_ARMED;
      cap        = prime && (state == S_ARMED || numberChecked != last_num);
      last_num_n = cap ? numberChecked : (prime ? last_num : '0);
   end
   // capture FSM state and last captured number
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_ARMED;
         last_num <= '0;
      end else begin
         state    <= state_n;
         last_num <= last_num_n;
      end
   end
   prime_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
      .clk(clk), .rst(rst), .push(cap), .push_data(numberChecked), .pop(pop),
      .full(full), .empty(empty), .count(fifo_count), .head(rd_data)
   );
   // saturating accepted-push counter and sticky drop flag
   always_ff @(posedge clk) begin
      if (rst) begin
         total_captured <= '0;
         overflow       <= 1'b0;
      end else begin
         if (push_ok && total_captured != '1) total_captured <= total_captured + 1'b1;
         if (cap && full && !pop) overflow <= 1'b1;
      end
   end
`ifdef PRIME_COLLECTOR_GAP_EN
   logic [DATA_W-1:0] prev, gap;
   logic have_prev;
   assign gap = numberChecked - prev;
   // largest gap between consecutive accepted primes within one scanner run
   always_ff @(posedge clk) begin
      if (rst || (state == S_HELD && !prime)) begin
         prev      <= '0;
         have_prev <= 1'b0;
         max_gap   <= '0;
      end else if (push_ok) begin
         prev      <= numberChecked;
         have_prev <= 1'b1;
         if (have_prev && gap > max_gap) max_gap <= gap;
      end
   end
`endif
endmodule

// File: tb/tb_prime_collector.sv
// tb_prime_collector: table-driven and directed checks of prime_collector
module tb_prime_collector;
   logic clk = 1'b0, rst, prime, rd_ready, rd_valid, overflow;
   logic [10:0] numberChecked, rd_data, total_captured;
   logic [4:0] fifo_count;
`ifdef PRIME_COLLECTOR_GAP_EN
   logic [10:0] max_gap;
`endif
   int n_cmp = 0, n_bad = 0;
   int primes[17] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59};
   typedef struct {
      logic rst; logic [10:0] num; logic prime; logic rdy;
      logic valid; logic [10:0] data; logic [4:0] cnt; logic [10:0] tot; logic ovf;
   } vec_t;
   vec_t vecs[$];

   prime_collector dut (
      .clk(clk), .rst(rst), .numberChecked(numberChecked), .prime(prime), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .fifo_count(fifo_count), .total_captured(total_captured),
`ifdef PRIME_COLLECTOR_GAP_EN
      .max_gap(max_gap),
`endif
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input int n, input logic p, input logic rdy);
      rst = r;
      numberChecked = 11'(n);
      prime = p;
      rd_ready = rdy;
   endtask

   task automatic add(input logic r, input int n, input logic p, input logic rdy,
                      input logic v, input int d, input int c, input int t, input logic o);
      vec_t x;
      x.rst = r; x.num = 11'(n); x.prime = p; x.rdy = rdy;
      x.valid = v; x.data = 11'(d); x.cnt = 5'(c); x.tot = 11'(t); x.ovf = o;
      vecs.push_back(x);
   endtask

   initial begin
      drive(1, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         add(0, primes[i], 1, 1, 1, primes[i], 1, i + 1, 0);
         for (int k = 0; k < 3; k++) add(0, primes[i], 1, 1, 0, primes[i], 0, i + 1, 0);
      end
      add(0, 9, 0, 1, 0, 7, 0, 4, 0);
      add(0, 11, 1, 1, 1, 11, 1, 5, 0);
      for (int k = 0; k < 5; k++) add(0, 11, 1, 1, 0, 11, 0, 5, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 2, 1, 0, 1, 2, 1, 1, 0);
      add(0, 2, 1, 0, 1, 2, 1, 1, 0);
      add(0, 2, 0, 0, 1, 2, 1, 1, 0);
      add(0, 2, 1, 0, 1, 2, 2, 2, 0);
      add(0, 0, 0, 1, 1, 2, 1, 2, 0);
      add(0, 0, 0, 1, 0, 2, 0, 2, 0);
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, int'(vecs[i].num), vecs[i].prime, vecs[i].rdy);
         step();
         chk($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].valid));
         chk($sformatf("row%0d rd_data", i), 32'(rd_data), 32'(vecs[i].data));
         chk($sformatf("row%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
         chk($sformatf("row%0d total", i), 32'(total_captured), 32'(vecs[i].tot));
         chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      end
      drive(1, 0, 0, 0); step();
      for (int i = 0; i < 17; i++) begin
         drive(0, primes[i], 1, 0); step();
         if (i == 15) begin
            chk("fill16 count", 32'(fifo_count), 16);
            chk("fill16 overflow", 32'(overflow), 0);
         end
      end
      chk("ovf count", 32'(fifo_count), 16);
      chk("ovf flag", 32'(overflow), 1);
      chk("ovf total", 32'(total_captured), 16);
      drive(0, 0, 0, 1);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d valid", i), 32'(rd_valid), 1);
         chk($sformatf("drain%0d data", i), 32'(rd_data), 32'(primes[i]));
         step();
      end
      chk("drained valid", 32'(rd_valid), 0);
      chk("drained count", 32'(fifo_count), 0);
      chk("drained overflow sticky", 32'(overflow), 1);
      for (int i = 0; i < 5; i++) begin
         drive(0, primes[i], 1, 0); step();
      end
      chk("mid count", 32'(fifo_count), 5);
      drive(1, 0, 0, 0); step();
      chk("mid rst valid", 32'(rd_valid), 0);
      chk("mid rst count", 32'(fifo_count), 0);
      chk("mid rst total", 32'(total_captured), 0);
      chk("mid rst overflow", 32'(overflow), 0);
      for (int i = 0; i < 16; i++) begin
         drive(0, primes[i], 1, 0); step();
      end
      drive(0, 59, 1, 1); step();
      chk("fullpop count", 32'(fifo_count), 16);
      chk("fullpop overflow", 32'(overflow), 0);
      chk("fullpop total", 32'(total_captured), 17);
      drive(0, 0, 0, 1);
      for (int i = 1; i < 17; i++) begin
         chk($sformatf("fullpop drain%0d", i), 32'(rd_data), 32'(primes[i]));
         step();
      end
      chk("fullpop empty", 32'(rd_valid), 0);
`ifdef PRIME_COLLECTOR_GAP_EN
      drive(1, 0, 0, 1); step();
      drive(0, 23, 1, 1); step();
      drive(0, 29, 1, 1); step();
      drive(0, 31, 1, 1); step();
      chk("max_gap", 32'(max_gap), 6);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
